// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, CTRL bit layout and loader FSM states
package uart_pkg;

  localparam logic [3:0] ADDR_CTRL = 4'd0;
  localparam logic [3:0] ADDR_TX   = 4'd4;
  localparam logic [3:0] ADDR_RX   = 4'd8;

  localparam int TX_EN   = 0;
  localparam int RX_EN   = 1;
  localparam int RX_STAT = 2;
  localparam int CPB_LSB = 3;
  localparam int CPB_MSB = 18;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_POLL_WR,
    ST_POLL_RD,
    ST_RD_DATA,
    ST_WORD,
    ST_MEM_REQ,
    ST_CHK,
    ST_DONE
  } state_e;

  // CTRL image: receiver on, transmitter off, baud divisor in its field
  function automatic logic [31:0] ctrl_word(input logic [15:0] cpb);
    logic [31:0] w;
    w                  = '0;
    w[CPB_MSB:CPB_LSB] = cpb;
    w[RX_EN]           = 1'b1;
    w[TX_EN]           = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/uart_byte_packer.sv
// rtl/uart_byte_packer.sv - little-endian byte-to-word assembler with lane counter
module uart_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  // Drop each byte into its lane; pulse word_valid after the fourth lane fills
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_o   <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
    end else begin
      word_valid_o <= 1'b0;
      if (clear_i) begin
        byte_cnt_o <= '0;
        word_o     <= '0;
      end else if (byte_valid_i) begin
        case (byte_cnt_o)
          2'd0:    word_o[7:0]   <= byte_i;
          2'd1:    word_o[15:8]  <= byte_i;
          2'd2:    word_o[23:16] <= byte_i;
          default: word_o[31:24] <= byte_i;
        endcase
        byte_cnt_o   <= byte_cnt_o + 2'd1;
        word_valid_o <= (byte_cnt_o == 2'd3);
      end
    end
  end

endmodule

// File: rtl/uart_prog_master.sv
// rtl/uart_prog_master.sv - serial boot loader writing a UART image into memory (option: UART_PROG_CHECKSUM_EN)
module uart_prog_master
  import uart_pkg::*;
#(
  parameter int AW        = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [15:0]   clks_per_bit_i,
  output logic          ren_o,
  output logic          we_o,
  output logic [3:0]    addr_o,
  output logic [31:0]   wdata_o,
  input  logic [31:0]   rdata_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  output logic          busy_o,
`ifdef UART_PROG_CHECKSUM_EN
  output logic          err_o,
`endif
  output logic          done_o
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  state_e        state;
  logic          last_status;
  logic          first_word;
  logic [CW-1:0] n_words;
  logic [CW-1:0] word_idx;
  logic [CW-1:0] n_clamped;
  logic [31:0]   ctrl_val;
  logic [31:0]   word;
  logic [1:0]    byte_cnt;
  logic          word_valid;
  logic          status;
  logic          byte_valid;
  logic          pk_clear;
  logic          last_word;
  logic          unused_rdata;

  assign ctrl_val     = ctrl_word(clks_per_bit_i);
  assign status       = rdata_i[RX_STAT];
  assign unused_rdata = ^rdata_i[31:8];
  assign n_clamped    = (word > 32'(MAX_WORDS)) ? CW'(MAX_WORDS) : word[CW-1:0];
  assign last_word    = ((word_idx + CW'(1)) == n_words);
  assign pk_clear     = (state == ST_IDLE) && start_i;

`ifdef UART_PROG_CHECKSUM_EN
  logic       chk_phase;
  logic [7:0] xor_acc;
  // The trailing checksum byte is compared, never packed into a word
  assign byte_valid = (state == ST_RD_DATA) && !chk_phase;
`else
  assign byte_valid = (state == ST_RD_DATA);
`endif

  uart_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pk_clear),
    .byte_valid_i (byte_valid),
    .byte_i       (rdata_i[7:0]),
    .byte_cnt_o   (byte_cnt),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Loader FSM; bus outputs are registered and set on entry to each state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      ren_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      last_status <= 1'b0;
      first_word  <= 1'b0;
      n_words     <= '0;
      word_idx    <= '0;
`ifdef UART_PROG_CHECKSUM_EN
      err_o       <= 1'b0;
      chk_phase   <= 1'b0;
      xor_acc     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_CFG;
            busy_o      <= 1'b1;
            we_o        <= 1'b1;
            addr_o      <= ADDR_CTRL;
            wdata_o     <= ctrl_val;
            first_word  <= 1'b1;
            word_idx    <= '0;
            n_words     <= '0;
            // a status level seen by a previous load must not mask a fresh byte
            last_status <= 1'b0;
`ifdef UART_PROG_CHECKSUM_EN
            err_o       <= 1'b0;
            chk_phase   <= 1'b0;
            xor_acc     <= '0;
`endif
          end
        end
        ST_CFG: begin
          state   <= ST_POLL_WR;
          we_o    <= 1'b1;
          addr_o  <= ADDR_CTRL;
          wdata_o <= ctrl_val;
        end
        ST_POLL_WR: begin
          state   <= ST_POLL_RD;
          we_o    <= 1'b0;
          ren_o   <= 1'b1;
          addr_o  <= ADDR_CTRL;
          wdata_o <= '0;
        end
        ST_POLL_RD: begin
          last_status <= status;
          // only a rising status consumes a byte
          if (status && !last_status) begin
            state  <= ST_RD_DATA;
            addr_o <= ADDR_RX;
          end else begin
            state   <= ST_POLL_WR;
            ren_o   <= 1'b0;
            we_o    <= 1'b1;
            wdata_o <= ctrl_val;
          end
        end
        ST_RD_DATA: begin
          ren_o  <= 1'b0;
          addr_o <= ADDR_CTRL;
`ifdef UART_PROG_CHECKSUM_EN
          if (chk_phase) begin
            err_o     <= (rdata_i[7:0] != xor_acc);
            chk_phase <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= ST_DONE;
          end else
`endif
          if (byte_cnt == 2'd3) begin
            state <= ST_WORD;
          end else begin
            state   <= ST_POLL_WR;
            we_o    <= 1'b1;
            wdata_o <= ctrl_val;
          end
        end
        ST_WORD: begin
          if (word_valid) begin
            if (first_word) begin
              first_word <= 1'b0;
              n_words    <= n_clamped;
              if (n_clamped == '0) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                state  <= ST_DONE;
              end else begin
                state   <= ST_POLL_WR;
                we_o    <= 1'b1;
                wdata_o <= ctrl_val;
              end
            end else begin
              state       <= ST_MEM_REQ;
              mem_req_o   <= 1'b1;
              mem_addr_o  <= AW'(BASE_ADDR) + AW'(word_idx);
              mem_wdata_o <= word;
`ifdef UART_PROG_CHECKSUM_EN
              xor_acc     <= xor_acc ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
`endif
            end
          end
        end
        ST_MEM_REQ: begin
          // request, address and data stay put until granted
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            word_idx  <= word_idx + CW'(1);
            if (last_word) begin
`ifdef UART_PROG_CHECKSUM_EN
              state  <= ST_CHK;
`else
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_DONE;
`endif
            end else begin
              state   <= ST_POLL_WR;
              we_o    <= 1'b1;
              wdata_o <= ctrl_val;
            end
          end
        end
`ifdef UART_PROG_CHECKSUM_EN
        ST_CHK: begin
          chk_phase <= 1'b1;
          state     <= ST_POLL_WR;
          we_o      <= 1'b1;
          wdata_o   <= ctrl_val;
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_prog_master.md
Name: uart_prog_master

Overview:
- Bus initiator that drives the UART register port (ren/we/addr/wdata/rdata) from the host side.
- Programs the UART control register, polls for received bytes and reads each one.
- Assembles the bytes into 32-bit little-endian words and issues sequential memory write requests.
- Serves as the boot/program loader: a host streams an image over serial and this block writes it into instruction memory.

Parameters:
- AW, 14, memory word-address width.
- BASE_ADDR, 0, first word address written.
- MAX_WORDS, 4096, upper bound on accepted word count; larger counts are clamped.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse, begins a load when idle.
- clks_per_bit_i  in  16  baud divisor written into CTRL[18:3].
- ren_o  out  1  UART register read strobe.
- we_o  out  1  UART register write strobe.
- addr_o  out  4  UART register address (0 CTRL, 4 TX, 8 RX).
- wdata_o  out  32  UART register write data.
- rdata_i  in  32  UART register read data, combinational on addr_o.
- mem_req_o  out  1  memory write request.
- mem_addr_o  out  AW  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse at load completion.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, word counter 0, last_status 0.
- Bus rules:
  - Write cycle: we_o=1, ren_o=0; the UART samples the write at the next edge.
  - Read cycle: ren_o=1, we_o=0; rdata_i is sampled in the same cycle.
  - Never assert ren_o and we_o together.
- CTRL value: wdata_o = {13'b0, clks_per_bit_i, 1'b0, rx_en=1, tx_en=0}.
- FSM states:
  - IDLE: on start_i, go to CFG; busy_o=1.
  - CFG: write CTRL once; go to POLL_WR.
  - POLL_WR: rewrite the identical CTRL value. This refreshes the status snapshot in CTRL[2]. Go to POLL_RD.
  - POLL_RD: read addr 0. status = rdata_i[2]. last_status <= status.
    - If status=1 and last_status=0, go to RD_DATA.
    - Otherwise go to POLL_WR.
    - A level that stays high is never consumed twice.
  - RD_DATA: read addr 8 and shift rdata_i[7:0] into byte position byte_cnt[1:0] (little-endian).
    - If byte_cnt[1:0]==3, go to WORD. Otherwise go to POLL_WR.
  - WORD: the first word of a load is the count N, clamped to MAX_WORDS.
    - N=0: go to DONE.
    - Other data words: go to MEM_REQ.
  - MEM_REQ: mem_req_o=1; mem_addr_o=BASE_ADDR+word_idx; data held stable.
    - Hold until mem_gnt_i, then word_idx++.
    - If word_idx+1==N, go to DONE (or CHK if enabled). Otherwise go to POLL_WR.
  - DONE: done_o=1 for one cycle, busy_o=0; go to IDLE.
- start_i while busy is ignored.
- Bytes arriving while in MEM_REQ are not buffered; the host paces one word per grant. Losing data this way is a protocol error, not handled.
- mem_addr_o wraps modulo 2^AW.
- Reset mid-load aborts immediately: no done pulse, and partial memory writes remain.

Optional Feature:
- Macro: UART_PROG_CHECKSUM_EN.
- Enabled:
  - After the N-th word, one more byte is received in state CHK.
  - It is compared with the XOR of all data bytes, excluding the count word.
  - Extra port err_o (out, 1) is set on mismatch, holds until the next start_i, and is cleared by reset.
  - done_o still pulses.
- Disabled: no CHK state, no err_o port; DONE follows the last grant.

Decomposition:
- Shared package uart_pkg holds:
  - Register address constants ADDR_CTRL=0, ADDR_TX=4, ADDR_RX=8.
  - CTRL bit positions: TX_EN=0, RX_EN=1, RX_STAT=2, CPB_LSB=3, CPB_MSB=18.
  - The FSM state enum typedef.
- One natural sub-module, uart_byte_packer: byte shift/assemble plus counter, emitting a word_valid pulse.

Test Plan:
- Count word N=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> writes 0x44332211 @BASE_ADDR, 0x88776655 @BASE_ADDR+1; done_o pulses once.
- Count N=0 -> no mem_req_o; done_o one cycle after the 4th count byte.
- Status stuck at 1 for 50 polls with a single byte -> exactly one RX read.
- mem_gnt_i held low 20 cycles -> mem_req_o, mem_addr_o and mem_wdata_o stay stable; no UART reads occur meanwhile.
- rst_ni low mid-word -> all outputs 0 asynchronously; a new start_i loads a fresh image correctly.
- With UART_PROG_CHECKSUM_EN: N=1, data 0x01,0x02,0x04,0x08, checksum 0x0F -> err_o=0. Checksum 0x0E -> err_o=1.
